ps2_key_ctrl: RTL and testbench

Control stage between the PS/2 byte receiver and the game logic. Consumes validated scan-code bytes, resolves the `E0` (extended) and `F0` (break) prefixes with a state machine, and tracks which of the five game keys are held. It arbitrates a single active direction and queues press/release events in a small ready/valid FIFO for the game FSM.

---
 rtl/ps2_key_pkg.sv | 56 +++++
 rtl/ps2_key_ctrl_if.sv | 21 ++
 rtl/ps2_evt_fifo.sv | 50 +++++
 rtl/ps2_key_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_pkg.sv
// Shared constants, key encoding and prefix-FSM state type for the PS/2 key
// control stage.
package ps2_key_pkg;

    // Scan-code bytes of interest
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // 3-bit key codes; held bit index is key code minus one
    localparam logic [2:0] KEY_NONE  = 3'd0;
    localparam logic [2:0] KEY_UP    = 3'd1;
    localparam logic [2:0] KEY_DOWN  = 3'd2;
    localparam logic [2:0] KEY_LEFT  = 3'd3;
    localparam logic [2:0] KEY_RIGHT = 3'd4;
    localparam logic [2:0] KEY_SPACE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } pfx_state_t;

    // Map a data byte to a key code; space is only valid without the E0 prefix
    function automatic logic [2:0] key_of(input logic [7:0] b, input logic ext);
        logic [2:0] k;
        k = KEY_NONE;
        case (b)
            SC_UP:    k = KEY_UP;
            SC_DOWN:  k = KEY_DOWN;
            SC_LEFT:  k = KEY_LEFT;
            SC_RIGHT: k = KEY_RIGHT;
            SC_SPACE: k = ext ? KEY_NONE : KEY_SPACE;
            default:  k = KEY_NONE;
        endcase
        return k;
    endfunction

    // Lowest key code whose held bit is set, or KEY_NONE
    function automatic logic [2:0] lowest_held(input logic [4:0] h);
        logic [2:0] k;
        k = KEY_NONE;
        for (int i = 4; i >= 0; i--) begin
            if (h[i]) begin
                k = 3'(i + 1);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Byte-input and event-output handshake bundle of ps2_key_ctrl.
// slave: the control stage; master: the byte source / event consumer side.
interface ps2_key_ctrl_if;
    logic       code_valid;
    logic [7:0] code_byte;
    logic       code_err;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_key;
    logic       evt_press;

    modport master (
        output code_valid, code_byte, code_err, evt_ready,
        input  evt_valid, evt_key, evt_press
    );

    modport slave (
        input  code_valid, code_byte, code_err, evt_ready,
        output evt_valid, evt_key, evt_press
    );
endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO. The head is presented combinationally
// from the storage array; a push into an empty FIFO is visible next cycle.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset since empty masks the head
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; extra MSB distinguishes full from empty
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key control stage: resolves E0/F0 prefixes, tracks the five game keys,
// arbitrates a single active key and queues press/release events.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (ignore makes of held keys).
module ps2_key_ctrl
    import ps2_key_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 CLK,
    input  logic                 RST,
    ps2_key_ctrl_if.slave        evt_if,
    output logic [4:0]           held,
    output logic [2:0]           active_key,
    output logic                 overflow
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    pfx_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [4:0]       held_reg, held_next;
    logic [2:0]       active_reg, active_next;
    logic             overflow_reg;

    logic             dec_ext;
    logic [2:0]       dec_key;
    logic             do_make;
    logic             do_break;
    logic [4:0]       key_mask;

    logic             push;
    logic [3:0]       push_data;
    logic             pop;
    logic [3:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    assign dec_ext  = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
    assign dec_key  = key_of(evt_if.code_byte, dec_ext);
    assign key_mask = (dec_key == KEY_NONE) ? 5'd0 : (5'd1 << (dec_key - 3'd1));

    // Prefix FSM and timeout counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Prefix FSM next state: byte decode has priority over the idle timeout
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        do_make    = 1'b0;
        do_break   = 1'b0;
        if (evt_if.code_valid) begin
            cnt_next = '0;
            if (evt_if.code_err) begin
                state_next = ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (evt_if.code_byte == SC_EXT) begin
                            state_next = ST_EXT;
                        end else if (evt_if.code_byte == SC_BRK) begin
                            state_next = ST_BRK;
                        end else if (dec_key != KEY_NONE) begin
                            do_make = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (evt_if.code_byte == SC_BRK) begin
                            state_next = ST_EXT_BRK;
                        end else begin
                            state_next = ST_IDLE;
                            do_make    = (dec_key != KEY_NONE);
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        do_break   = (dec_key != KEY_NONE);
                    end
                endcase
            end
        end else if (state_reg != ST_IDLE) begin
            if (cnt_reg == CNT_LAST) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else begin
            cnt_next = '0;
        end
    end

    // Held bitmap, active-key arbitration and event generation
    always_comb begin
        held_next   = held_reg;
        active_next = active_reg;
        push        = 1'b0;
        push_data   = {do_make, dec_key};
        if (do_make) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if ((held_reg & key_mask) == 5'd0) begin
                held_next   = held_reg | key_mask;
                active_next = dec_key;
                push        = 1'b1;
            end
`else
            held_next   = held_reg | key_mask;
            active_next = dec_key;
            push        = 1'b1;
`endif
        end else if (do_break && ((held_reg & key_mask) != 5'd0)) begin
            held_next = held_reg & ~key_mask;
            push      = 1'b1;
            if (active_reg == dec_key) begin
                active_next = lowest_held(held_reg & ~key_mask);
            end
        end
    end

    // Key tracking registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            held_reg   <= '0;
            active_reg <= KEY_NONE;
        end else begin
            held_reg   <= held_next;
            active_reg <= active_next;
        end
    end

    // Sticky overflow: an event was lost to a full queue with no pop
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_reg <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign pop = !fifo_empty && evt_if.evt_ready;

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_if.evt_valid = !fifo_empty;
    assign evt_if.evt_press = fifo_head[3];
    assign evt_if.evt_key   = fifo_head[2:0];
    assign held             = held_reg;
    assign active_key       = active_reg;
    assign overflow         = overflow_reg;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: directed and randomized byte streams,
// a prefix/key reference model, and a scoreboard-driven event monitor.
module tb_ps2_key_ctrl;
    localparam int DEPTH = 4;
    localparam int T     = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] held;
    logic [2:0] active_key;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_key_ctrl_if ifc ();

    ps2_key_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (T)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .evt_if     (ifc),
        .held       (held),
        .active_key (active_key),
        .overflow   (overflow)
    );

    int          checks   = 0;
    int          failures = 0;
    longint      cyc      = 0;
    bit          rand_ready = 1'b0;

    // Reference model state
    bit          m_ext;
    bit          m_brk;
    longint      m_last;
    bit [4:0]    m_held;
    int          m_active;
    bit          m_ovf;
    logic [3:0]  sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [4:0] h);
        for (int i = 0; i < 5; i++) if (h[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_push(input int k, input bit press);
        if (sb.size() >= DEPTH) m_ovf = 1'b1;
        else sb.push_back({press, 3'(k)});
    endtask

    // Reference behaviour of one received byte at bench cycle c
    task automatic model_byte(input logic [7:0] b, input bit err, input longint c);
        int k;
        if ((m_ext || m_brk) && (c - m_last > T)) begin
            m_ext = 0; m_brk = 0;
        end
        m_last = c;
        if (err) begin
            m_ext = 0; m_brk = 0;
            return;
        end
        k = 0;
        case (b)
            8'h75: k = 1;
            8'h72: k = 2;
            8'h6B: k = 3;
            8'h74: k = 4;
            8'h29: k = m_ext ? 0 : 5;
            default: k = 0;
        endcase
        if (b == 8'hE0) begin
            if (!m_ext && !m_brk) m_ext = 1;
            else begin m_ext = 0; m_brk = 0; end
        end else if (b == 8'hF0) begin
            if (!m_brk) m_brk = 1;
            else begin m_ext = 0; m_brk = 0; end
        end else begin
            if (k != 0) begin
                if (m_brk) begin
                    if (m_held[k-1]) begin
                        m_held[k-1] = 1'b0;
                        model_push(k, 1'b0);
                        if (m_active == k) m_active = lowest(m_held);
                    end
                end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (!m_held[k-1]) begin
                        m_held[k-1] = 1'b1;
                        m_active = k;
                        model_push(k, 1'b1);
                    end
`else
                    m_held[k-1] = 1'b1;
                    m_active = k;
                    model_push(k, 1'b1);
`endif
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Called at posedge+1; drives one byte for one cycle and checks state after it
    task automatic send(input logic [7:0] b, input bit err);
        longint c;
        ifc.code_valid = 1'b1;
        ifc.code_byte  = b;
        ifc.code_err   = err;
        c = cyc;
        @(posedge clk); #1;
        ifc.code_valid = 1'b0;
        ifc.code_err   = 1'b0;
        ifc.code_byte  = 8'($urandom);
        model_byte(b, err, c);
        $display("byte=%02h err=%0d held=%05b active=%0d ovf=%0d", b, err, held, active_key, overflow);
        check("held", 32'(held), 32'(m_held));
        check("active_key", 32'(active_key), 32'(m_active));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rand_ready     = 1'b0;
        ifc.evt_ready  = 1'b0;
        ifc.code_valid = 1'b0;
        ifc.code_err   = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        sb.delete();
        m_ext = 0; m_brk = 0; m_last = 0; m_held = '0; m_active = 0; m_ovf = 0;
        check("rst_held", 32'(held), 32'd0);
        check("rst_active", 32'(active_key), 32'd0);
        check("rst_evt_valid", 32'(ifc.evt_valid), 32'd0);
        check("rst_evt_key", 32'(ifc.evt_key), 32'd0);
        check("rst_evt_press", 32'(ifc.evt_press), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each accepted head, checks stall stability
    initial begin
        bit         stall_prev = 1'b0;
        logic [4:0] stall_val  = '0;
        logic [3:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_hold", 32'({ifc.evt_valid, ifc.evt_press, ifc.evt_key}), 32'(stall_val));
                end
                if (ifc.evt_valid && ifc.evt_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_evt actual=%0d/%0d expected=none", ifc.evt_key, ifc.evt_press);
                    end else begin
                        exp = sb.pop_front();
                        $display("evt key=%0d press=%0d", ifc.evt_key, ifc.evt_press);
                        check("evt", 32'({ifc.evt_press, ifc.evt_key}), 32'(exp));
                    end
                end
                stall_prev = ifc.evt_valid && !ifc.evt_ready;
                stall_val  = {1'b1, ifc.evt_press, ifc.evt_key};
            end
        end
    end

    // Random consumer back-pressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) ifc.evt_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [7:0] pick [10];
        int         n;
        int         r;
        ifc.code_valid = 1'b0;
        ifc.code_byte  = 8'h00;
        ifc.code_err   = 1'b0;
        ifc.evt_ready  = 1'b0;
        @(posedge clk); #1;
        do_reset();

        ifc.evt_ready = 1'b1;
        // Press then release up
        send(8'h75, 0); send(8'hF0, 0); send(8'h75, 0);
        drain(20);
        // Extended left, space, release space: active falls back to left
        send(8'hE0, 0); send(8'h6B, 0); send(8'h29, 0);
        send(8'hF0, 0); send(8'h29, 0);
        check("fallback_active", 32'(active_key), 32'd3);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 0);
        drain(20);
        // Timeout: prefix abandoned after T idle cycles, kept at T-1
        send(8'hF0, 0); idle(T); send(8'h75, 0);
        check("timeout_make", 32'(held[0]), 32'd1);
        send(8'hF0, 0); idle(T - 1); send(8'h75, 0);
        check("no_timeout_break", 32'(held[0]), 32'd0);
        send(8'hE0, 0); idle(T); send(8'h29, 0);
        send(8'hF0, 0); send(8'h29, 0);
        drain(20);
        // Error on F0: following byte is a make
        send(8'hF0, 1); send(8'h75, 0);
        check("err_make", 32'(held[0]), 32'd1);
        // Typematic repeat
        send(8'h75, 0);
        send(8'hF0, 0); send(8'h75, 0);
        drain(20);

        // Overflow with consumer stalled
        do_reset();
        send(8'h75, 0); send(8'h72, 0); send(8'h6B, 0); send(8'h74, 0); send(8'h29, 0);
        check("ovf_set", 32'(overflow), 32'd1);
        ifc.evt_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_no_gap", 32'(ifc.evt_valid), 32'd1);
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(ifc.evt_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-sequence and mid-handshake
        ifc.evt_ready = 1'b0;
        send(8'hF0, 0); send(8'h75, 0); send(8'hE0, 0);
        do_reset();
        ifc.evt_ready = 1'b1;
        send(8'h74, 0);
        check("post_rst_make", 32'(held), 32'h08);
        drain(20);

        // Randomized traffic with random back-pressure
        pick[0] = 8'hE0; pick[1] = 8'hF0; pick[2] = 8'h75; pick[3] = 8'h72;
        pick[4] = 8'h6B; pick[5] = 8'h74; pick[6] = 8'h29; pick[7] = 8'hE0;
        pick[8] = 8'hF0; pick[9] = 8'h00;
        rand_ready = 1'b1;
        for (int it = 0; it < 400; it++) begin
            logic [7:0] b;
            n = 0;
            while (sb.size() >= DEPTH - 1 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 200) check("sb_wait_timeout", 32'(sb.size()), 32'(DEPTH - 2));
            r = $urandom_range(0, 9);
            b = (r == 9) ? 8'($urandom) : pick[r];
            send(b, ($urandom_range(0, 15) == 0));
            r = $urandom_range(0, 15);
            if (r < 10) idle(r % 4);
            else if (r < 13) idle(T - 2 + (r - 10));
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        ifc.evt_ready = 1'b1;
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
